// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Resolves branches and performs word loads/stores against a multi-cycle
// internal data memory. Holds the upstream pipeline with stall while an
// access is in flight.
//
// Handshake: a load/store is presented on mem_read/mem_write/addr/wdata and
// must stay stable while stall=1. The request is accepted in IDLE when it is
// word-aligned; index, data and op are captured on that edge. Completion is
// signalled by a one-cycle mem_done pulse (state DONE) with stall=0, during
// which rdata carries the load result. Misaligned requests are dropped and
// flagged with misaligned=1 without stalling.
module mem_stage #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] branch_target,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_in,
   output logic        pc_src,
   output logic [31:0] pc_branch,
   output logic        stall,
   output logic [31:0] rdata,
   output logic [31:0] alu_out,
   output logic [4:0]  rd_out,
   output logic        misaligned,
   output logic        mem_done,
   output logic [1:0]  state_dbg
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            write_q;
   logic [31:0]     mem [DEPTH];

   logic            req;
   logic            aligned;
   logic            start;
   logic            last_cycle;
   logic            mem_we;

   assign req        = mem_read | mem_write;
   assign aligned    = (addr[1:0] == 2'b00);
   assign start      = (state == IDLE) && req && aligned;
   assign last_cycle = (state == ACCESS) && (cnt == 4'd0);
   assign mem_we     = last_cycle && write_q;

   // Access FSM: capture the request, count down the latency, complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata   <= 32'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         write_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx_q   <= addr[AW+1:2];
                  wdata_q <= wdata;
                  // A simultaneous read+write request is treated as a store.
                  write_q <= mem_write;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  if (!write_q) rdata <= mem[idx_q];
                  state <= DONE;
               end
            end
            DONE: begin
               // Inputs still show the finished instruction; ignore them.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data memory array: cleared on reset, written on the last ACCESS cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      end else if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign stall      = start || (state == ACCESS);
   assign mem_done   = (state == DONE);
   assign misaligned = (state == IDLE) && req && !aligned;
   assign pc_src     = branch && zero && (state == IDLE);
   assign pc_branch  = branch_target;
   assign alu_out    = addr;
   assign rd_out     = rd_in;
   assign state_dbg  = state;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage with a word-array reference.
module tb_mem_stage;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        zero;
   logic [31:0] branch_target;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [4:0]  rd_in;
   logic        pc_src;
   logic [31:0] pc_branch;
   logic        stall;
   logic [31:0] rdata;
   logic [31:0] alu_out;
   logic [4:0]  rd_out;
   logic        misaligned;
   logic        mem_done;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] exp_rdata;
   logic [31:0] exp_q [$];

   mem_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .zero(zero), .branch_target(branch_target),
      .addr(addr), .wdata(wdata), .rd_in(rd_in), .pc_src(pc_src),
      .pc_branch(pc_branch), .stall(stall), .rdata(rdata), .alu_out(alu_out),
      .rd_out(rd_out), .misaligned(misaligned), .mem_done(mem_done),
      .state_dbg(state_dbg)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int word_idx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      exp_rdata = 32'd0;
   endfunction

   // Driver: present a memory op (called just after a rising edge), follow it
   // to its completion pulse and report what was observed. Leaves the bench
   // just after the edge that ends DONE, with memory inputs cleared.
   task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int stall_cycles,
                         output bit done_seen, output logic [31:0] rd_at_done,
                         output logic stall_in_done, output logic first_stall);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      stall_cycles = 0; done_seen = 0; rd_at_done = 'x; stall_in_done = 'x;
      first_stall = 'x;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (i == 0) first_stall = stall;
         if (mem_done) begin
            done_seen = 1; rd_at_done = rdata; stall_in_done = stall;
         end else if (stall) begin
            stall_cycles++;
         end
         @(posedge clk); #1;
      end
      mem_read = 0; mem_write = 0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      model_reset();
      @(negedge clk);
      n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      n_checks++; if (mem_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", mem_done); end
      n_checks++; if (state_dbg !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
      @(posedge clk); #1;
      run_op(1, 0, 32'h40, 32'h0, sc, dn, r, sd, fs);
      n_checks++; if (dn !== 1'b1) begin n_errors++; $display("FAIL reset_read_done got=%b exp=1", dn); end
      n_checks++; if (r !== 32'd0) begin n_errors++; $display("FAIL reset_read_0x40 got=%h exp=0", r); end
   endtask

   task automatic test_store_load();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      run_op(0, 1, 32'h10, 32'hDEADBEEF, sc, dn, r, sd, fs);
      ref_mem[word_idx(32'h10)] = 32'hDEADBEEF;
      n_checks++; if (sc != 1 + LAT) begin n_errors++; $display("FAIL store_stall_cycles got=%0d exp=%0d", sc, 1 + LAT); end
      n_checks++; if (dn !== 1'b1) begin n_errors++; $display("FAIL store_done got=%b exp=1", dn); end
      n_checks++; if (sd !== 1'b0) begin n_errors++; $display("FAIL store_stall_in_done got=%b exp=0", sd); end
      @(negedge clk);
      n_checks++; if (mem_done !== 1'b0) begin n_errors++; $display("FAIL done_one_cycle got=%b exp=0", mem_done); end
      @(posedge clk); #1;
      run_op(1, 0, 32'h10, 32'h0, sc, dn, r, sd, fs);
      exp_rdata = ref_mem[word_idx(32'h10)];
      n_checks++; if (sc != 1 + LAT) begin n_errors++; $display("FAIL load_stall_cycles got=%0d exp=%0d", sc, 1 + LAT); end
      n_checks++; if (r !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_rdata got=%h exp=deadbeef", r); end
      idle_cycle(); idle_cycle();
      @(negedge clk);
      n_checks++; if (rdata !== exp_rdata) begin n_errors++; $display("FAIL load_rdata_hold got=%h exp=%h", rdata, exp_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      run_op(0, 1, 32'h400, 32'h12345678, sc, dn, r, sd, fs);
      ref_mem[word_idx(32'h400)] = 32'h12345678;
      run_op(1, 0, 32'h0, 32'h0, sc, dn, r, sd, fs);
      exp_rdata = ref_mem[word_idx(32'h0)];
      n_checks++; if (r !== 32'h12345678) begin n_errors++; $display("FAIL wrap_rdata got=%h exp=12345678", r); end
   endtask

   task automatic test_misaligned();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      run_op(1, 0, 32'h10, 32'h0, sc, dn, r, sd, fs);
      exp_rdata = ref_mem[word_idx(32'h10)];
      mem_read = 1; addr = 32'h13;
      @(negedge clk);
      n_checks++; if (misaligned !== 1'b1) begin n_errors++; $display("FAIL misaligned_flag got=%b exp=1", misaligned); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL misaligned_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (state_dbg !== 2'd0) begin n_errors++; $display("FAIL misaligned_state got=%0d exp=0", state_dbg); end
      n_checks++; if (rdata !== exp_rdata) begin n_errors++; $display("FAIL misaligned_rdata got=%h exp=%h", rdata, exp_rdata); end
      @(posedge clk); #1;
      mem_read = 0; mem_write = 1; addr = 32'h11; wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_write = 0;
      run_op(1, 0, 32'h10, 32'h0, sc, dn, r, sd, fs);
      n_checks++; if (r !== ref_mem[word_idx(32'h10)]) begin n_errors++; $display("FAIL misaligned_no_write got=%h exp=%h", r, ref_mem[word_idx(32'h10)]); end
   endtask

   task automatic test_branch();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      branch = 1; zero = 1; branch_target = 32'h80; addr = 32'h1234; rd_in = 5'd17;
      @(negedge clk);
      n_checks++; if (pc_src !== 1'b1) begin n_errors++; $display("FAIL branch_taken got=%b exp=1", pc_src); end
      n_checks++; if (pc_branch !== 32'h80) begin n_errors++; $display("FAIL branch_target got=%h exp=80", pc_branch); end
      n_checks++; if (alu_out !== 32'h1234 || rd_out !== 5'd17) begin n_errors++; $display("FAIL passthrough got=%h/%0d exp=1234/17", alu_out, rd_out); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL nonmem_stall got=%b exp=0", stall); end
      zero = 0;
      #1;
      n_checks++; if (pc_src !== 1'b0) begin n_errors++; $display("FAIL branch_not_taken got=%b exp=1'b0", pc_src); end
      @(posedge clk); #1;
      branch = 0;
      // A branch seen while an access is busy must not redirect.
      mem_write = 1; addr = 32'h30; wdata = 32'h77;
      @(posedge clk); #1;
      branch = 1; zero = 1;
      @(negedge clk);
      n_checks++; if (pc_src !== 1'b0) begin n_errors++; $display("FAIL branch_in_access got=%b exp=0", pc_src); end
      branch = 0; zero = 0;
      ref_mem[word_idx(32'h30)] = 32'h77;
      for (int i = 0; i < 10 && state_dbg != 2'd0; i++) begin @(posedge clk); #1; end
      mem_write = 0;
      run_op(1, 0, 32'h30, 32'h0, sc, dn, r, sd, fs);
      exp_rdata = ref_mem[word_idx(32'h30)];
      n_checks++; if (r !== 32'h77) begin n_errors++; $display("FAIL branch_store_read got=%h exp=77", r); end
   endtask

   task automatic test_reset_mid_access();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      mem_write = 1; addr = 32'h20; wdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (state_dbg !== 2'd1) begin n_errors++; $display("FAIL mid_state_access got=%0d exp=1", state_dbg); end
      rst = 1; mem_write = 0;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      @(negedge clk);
      n_checks++; if (state_dbg !== 2'd0) begin n_errors++; $display("FAIL mid_state_idle got=%0d exp=0", state_dbg); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL mid_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      run_op(1, 0, 32'h20, 32'h0, sc, dn, r, sd, fs);
      n_checks++; if (r !== 32'd0) begin n_errors++; $display("FAIL mid_read_0x20 got=%h exp=0", r); end
      run_op(1, 0, 32'h10, 32'h0, sc, dn, r, sd, fs);
      n_checks++; if (r !== 32'd0) begin n_errors++; $display("FAIL mid_mem_cleared got=%h exp=0", r); end
   endtask

   task automatic test_back_to_back();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      run_op(0, 1, 32'h44, 32'h0BADF00D, sc, dn, r, sd, fs);
      ref_mem[word_idx(32'h44)] = 32'h0BADF00D;
      run_op(1, 0, 32'h44, 32'h0, sc, dn, r, sd, fs);
      exp_rdata = ref_mem[word_idx(32'h44)];
      n_checks++; if (fs !== 1'b1) begin n_errors++; $display("FAIL b2b_no_bubble got=%b exp=1", fs); end
      n_checks++; if (sc != 1 + LAT) begin n_errors++; $display("FAIL b2b_stall_cycles got=%0d exp=%0d", sc, 1 + LAT); end
      n_checks++; if (r !== 32'h0BADF00D) begin n_errors++; $display("FAIL b2b_rdata got=%h exp=0badf00d", r); end
      // Read+write together acts as a store and leaves rdata alone.
      run_op(1, 1, 32'h48, 32'h5555AAAA, sc, dn, r, sd, fs);
      ref_mem[word_idx(32'h48)] = 32'h5555AAAA;
      n_checks++; if (r !== exp_rdata) begin n_errors++; $display("FAIL rw_rdata_hold got=%h exp=%h", r, exp_rdata); end
      run_op(1, 0, 32'h48, 32'h0, sc, dn, r, sd, fs);
      exp_rdata = ref_mem[word_idx(32'h48)];
      n_checks++; if (r !== 32'h5555AAAA) begin n_errors++; $display("FAIL rw_as_write got=%h exp=5555aaaa", r); end
   endtask

   task automatic test_random();
      int sc; bit dn; logic [31:0] r; logic sd, fs;
      logic [31:0] a, d, e;
      logic rd, wr;
      for (int n = 0; n < 60; n++) begin
         a = $urandom;
         // Keep most addresses small so stores and loads collide often.
         if ($urandom_range(0, 1) == 1) a = a & 32'h0000_01FF;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         d = $urandom;
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if (!(rd || wr) || a[1:0] != 2'b00) begin
            mem_read = rd; mem_write = wr; addr = a; wdata = d;
            @(negedge clk);
            n_checks++; if (stall !== 1'b0 || misaligned !== (rd | wr)) begin
               n_errors++; $display("FAIL rnd_nonaccess got=%b%b exp=0%b", stall, misaligned, rd | wr);
            end
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0;
         end else begin
            if (wr) ref_mem[word_idx(a)] = d;
            else exp_rdata = ref_mem[word_idx(a)];
            exp_q.push_back(exp_rdata);
            run_op(rd, wr, a, d, sc, dn, r, sd, fs);
            n_checks++; if (dn !== 1'b1 || sc != 1 + LAT) begin
               n_errors++; $display("FAIL rnd_timing got=%b/%0d exp=1/%0d", dn, sc, 1 + LAT);
            end
            e = exp_q.pop_front();
            n_checks++; if (r !== e) begin
               n_errors++; $display("FAIL rnd_rdata addr=%h got=%h exp=%h", a, r, e);
            end
         end
      end
   endtask

   initial begin
      rst = 1; mem_read = 0; mem_write = 0; branch = 0; zero = 0;
      branch_target = 0; addr = 0; wdata = 0; rd_in = 0;
      model_reset();
      test_reset();
      test_store_load();
      test_wrap();
      test_misaligned();
      test_branch();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. Consumes the registered EX/MEM outputs (branch target, zero flag, ALU result, store data, destination register) and resolves branches. Performs word loads and stores against an internal multi-cycle data memory. Asserts `stall` to freeze upstream pipeline registers while an access is in flight.

## Interface
- DEPTH, 256: data memory size in 32-bit words, power of 2.
- LATENCY, 2: access cycles spent in ACCESS, legal range 1..15.
- Reset `rst` is synchronous and active-high; the clock is `clk`.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- branch  in  1  instruction is a conditional branch.
- zero  in  1  ALU zero flag.
- branch_target  in  32  computed branch address.
- addr  in  32  byte address from the ALU result.
- wdata  in  32  store data.
- rd_in  in  5  destination register.
- pc_src  out  1  take the branch.
- pc_branch  out  32  branch target to the PC mux.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- rdata  out  32  registered load data.
- alu_out  out  32  `addr` passthrough.
- rd_out  out  5  `rd_in` passthrough.
- misaligned  out  1  request ignored because `addr[1:0]` != 0.
- mem_done  out  1  one-cycle pulse when an access completes.

## Operation
- **Memory indexing:** memory is a `DEPTH` x 32 array.
- **Index:** `addr[log2(DEPTH)+1:2]`.
- **Wrap:** higher address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- **FSM:** three states, IDLE, ACCESS and DONE.
- **IDLE, request:** if `(mem_read|mem_write)` and `addr[1:0]==0`:
  - latch the index, `wdata` and op into internal registers;
  - load `cnt <= LATENCY-1`;
  - go to ACCESS.
- **ACCESS, `cnt!=0`:** `cnt <= cnt-1`.
- **ACCESS, `cnt==0`:**
  - write: `mem[idx] <= wdata_latched`;
  - read: `rdata <= mem[idx]`;
  - go to DONE.
- **DONE:** inputs are ignored; go to IDLE unconditionally. This prevents the still-held instruction from re-triggering.
- **Both `mem_read` and `mem_write`:** treated as a write; `rdata` is unchanged.
- **Misaligned:** request in IDLE with `addr[1:0]!=0`:
  - `misaligned=1` (combinational);
  - no access, no stall, FSM stays in IDLE;
  - `rdata` is unchanged.
- **`stall`:** `(IDLE & (mem_read|mem_write) & addr[1:0]==0) | ACCESS`.
- **`mem_done`:** 1 exactly in DONE.
- **`pc_src`:** `branch & zero & (state==IDLE)`.
- **Passthroughs:** `pc_branch = branch_target`, `alu_out = addr`, `rd_out = rd_in`; all combinational.
- **`rdata` hold:** holds its value until the next completed read.

## Timing
- **Reset:**
  - state=IDLE, cnt=0, rdata=0;
  - all memory words = 0;
  - stall, mem_done, pc_src and misaligned then follow their equations from IDLE.
- **Latched state:** the index, data and op are captured at the IDLE→ACCESS edge. Input changes during ACCESS have no effect.
- **Stall duration:** a memory instruction stalls for `1+LATENCY` cycles. Its occupancy in MEM is `LATENCY+2` cycles, including DONE.
- **Load data:** valid on `rdata` in the DONE cycle, concurrently with `mem_done=1` and `stall=0`. The MEM/WB register captures it at the edge ending DONE.
- **Back-to-back accesses:** the next instruction is evaluated in the IDLE cycle after DONE, with no extra bubble.
- **Reset mid-access:** return to IDLE. A pending write is discarded and memory is cleared.
- **Non-memory instructions:** in IDLE they pass through with zero added latency.

## Test plan
- **Reset:** assert rst for 2 cycles → rdata=0, stall=0, mem_done=0, and a read of address 0x40 returns 0.
- **Store then load (LATENCY=2):**
  - store 0xDEADBEEF to 0x10: stall=1 for 3 cycles, then mem_done=1 for 1 cycle;
  - load from 0x10: rdata=0xDEADBEEF in the DONE cycle and held afterwards.
- **Wrap:** store 0x12345678 to 0x400 with DEPTH=256 → load from 0x000 returns 0x12345678.
- **Misaligned:** load from 0x13 → misaligned=1, stall=0, state stays IDLE, rdata unchanged.
- **Branch:** branch=1, zero=1, branch_target=0x00000080 in IDLE → pc_src=1, pc_branch=0x80. The same inputs with zero=0 → pc_src=0.
- **Reset mid-access:**
  - store 0xA5A5A5A5 to 0x20, then assert rst in the first ACCESS cycle → state=IDLE, stall=0;
  - load from 0x20 returns 0.
